// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register for the MIPS pipeline.
// Selects the register-file write value (ALU, load, link, immediate),
// extracts and extends sub-word loads, flags misaligned/illegal loads,
// and counts retired instructions.
module wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [DATA_WIDTH-1:0]     i_link_addr,
  input  logic [DATA_WIDTH-1:0]     i_imm,
  input  logic [1:0]                i_wb_sel,
  input  logic [1:0]                i_load_size,
  input  logic                      i_load_unsigned,
  input  logic                      i_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
  output logic                      o_wb_regwrite,
  output logic                      o_valid,
  output logic                      o_misaligned,
  output logic [COUNT_WIDTH-1:0]    o_retired
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;
  localparam logic [1:0] SEL_IMM  = 2'd3;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Keep the low 'bits' of raw and extend them to the full datapath width.
  function automatic logic [DATA_WIDTH-1:0] extend_field(
    input logic [DATA_WIDTH-1:0] raw,
    input int unsigned           bits,
    input logic                  zext
  );
    logic [DATA_WIDTH-1:0] up;
    up = raw << (DATA_WIDTH - bits);
    if (zext) begin
      return up >> (DATA_WIDTH - bits);
    end else begin
      return $signed(up) >>> (DATA_WIDTH - bits);
    end
  endfunction

  logic [OFF_W-1:0]          offset;
  logic [DATA_WIDTH-1:0]     lane_data;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      bad_align;
  logic                      load_mis;
  logic [DATA_WIDTH-1:0]     next_data;
  logic                      next_we;
  logic                      retire_fire;

  // Load extraction: shift the addressed lane down, then extend by size.
  always_comb begin
    offset    = i_alu_result[OFF_W-1:0];
    lane_data = i_mem_data >> {offset, 3'b000};
    load_data = lane_data;
    bad_align = 1'b0;
    case (i_load_size)
      SZ_BYTE: begin
        load_data = extend_field(lane_data, 32'd8, i_load_unsigned);
        bad_align = 1'b0;
      end
      SZ_HALF: begin
        load_data = extend_field(lane_data, 32'd16, i_load_unsigned);
        bad_align = offset[0];
      end
      SZ_WORD: begin
        load_data = extend_field(lane_data, 32'd32, i_load_unsigned);
        bad_align = |offset[1:0];
      end
      SZ_DWORD: begin
        // Doubleword is the whole bus; on a 32-bit datapath it is illegal.
        load_data = i_mem_data;
        if (DATA_WIDTH == 64) begin
          bad_align = |offset;
        end else begin
          bad_align = 1'b1;
        end
      end
      default: begin
        load_data = lane_data;
        bad_align = 1'b1;
      end
    endcase
  end

  // Source select and write-enable qualification for the next stage value.
  always_comb begin
    load_mis = (i_wb_sel == SEL_LOAD) & bad_align;
    case (i_wb_sel)
      SEL_ALU:  next_data = i_alu_result;
      SEL_LOAD: next_data = load_data;
      SEL_LINK: next_data = i_link_addr;
      SEL_IMM:  next_data = i_imm;
      default:  next_data = i_alu_result;
    endcase
    next_we     = i_valid & i_regwrite & (i_rd != {REG_ADDR_WIDTH{1'b0}}) & ~load_mis;
    // A flush overrides a stall, so the held instruction leaves either way.
    retire_fire = o_valid & ~o_misaligned & (i_flush | ~i_stall);
  end

  // Stage register: flush beats stall; data/rd are kept across a flush.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_wb_data     <= {DATA_WIDTH{1'b0}};
      o_wb_rd       <= {REG_ADDR_WIDTH{1'b0}};
      o_wb_regwrite <= 1'b0;
      o_valid       <= 1'b0;
      o_misaligned  <= 1'b0;
    end else if (i_flush) begin
      o_wb_regwrite <= 1'b0;
      o_valid       <= 1'b0;
      o_misaligned  <= 1'b0;
    end else if (!i_stall) begin
      o_wb_data     <= next_data;
      o_wb_rd       <= i_rd;
      o_wb_regwrite <= next_we;
      o_valid       <= i_valid;
      o_misaligned  <= load_mis & i_valid;
    end
  end

  // Retire counter: counts well-formed instructions as they leave the stage.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_retired <= {COUNT_WIDTH{1'b0}};
    end else if (retire_fire) begin
      o_retired <= o_retired + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule
